// File: rtl/seg_pkg.sv
// Shared types and segment constants for the seven-segment readback monitor.
package seg_pkg;

    typedef logic [6:0] seg_t;

    // abcdefg, active-high, bit 6 = a ... bit 0 = g
    localparam seg_t SEG_HEX [0:15] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    typedef enum logic {
        EMPTY  = 1'b0,
        LOCKED = 1'b1
    } state_e;

endpackage

// File: rtl/seg_decode.sv
// Combinational seven-segment to hex digit decoder; anything outside the
// sixteen hex glyphs (including all-dark) is reported as illegal.
module seg_decode
    import seg_pkg::*;
(
    input  seg_t       seg_i,
    output logic [3:0] digit_o,
    output logic       legal_o
);

    always_comb begin
        digit_o = '0;
        legal_o = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (seg_i == SEG_HEX[i]) begin
                digit_o = 4'(i);
                legal_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_readback.sv
// Segment readback monitor: filters the two-digit display lines, decodes them
// back to a 6-bit count and checks that the count only steps by +1 or clears.
//
// state  | meaning
// EMPTY  | no legal count accepted since reset, value not valid
// LOCKED | value holds the last accepted count, sequence checks enabled
module seg_readback
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [6:0] seg1,
    input  logic [6:0] seg2,
    output logic [5:0] value,
    output logic       value_valid,
    output logic       update,
    output logic       seq_err,
    output logic       bad_pattern,
    output logic [7:0] err_count
);

    localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

    logic [13:0] sample_w;
    logic [13:0] s_q;
    logic [3:0]  cnt_q, cnt_d;
    logic        same_w;
    logic        accept_w;

    logic [3:0]  dig1_w, dig2_w;
    logic        legal1_w, legal2_w;
    logic        legal_w;
    logic [5:0]  n_w;
    logic [5:0]  value_inc_w;

    state_e      state_q, state_d;
    logic [5:0]  value_q, value_d;
    logic        load_w;
    logic        update_q, update_d;
    logic        seq_err_q, seq_err_d;
    logic        bad_q, bad_d;
    logic [7:0]  err_q, err_d;

    assign sample_w = SEG_ACTIVE_LOW ? ~{seg2, seg1} : {seg2, seg1};
    assign same_w   = (sample_w == s_q);

    // Accept fires on the one edge where the counter would reach the threshold.
    always_comb begin
        cnt_d = cnt_q;
        if (!same_w) begin
            cnt_d = '0;
        end else if (cnt_q < STABLE_C) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    assign accept_w = same_w && (cnt_q == STABLE_C - 4'd1);

    seg_decode u_dec1 (
        .seg_i   (s_q[6:0]),
        .digit_o (dig1_w),
        .legal_o (legal1_w)
    );

    seg_decode u_dec2 (
        .seg_i   (s_q[13:7]),
        .digit_o (dig2_w),
        .legal_o (legal2_w)
    );

    assign legal_w     = legal1_w && legal2_w && (dig2_w <= 4'd3);
    assign n_w         = {dig2_w[1:0], dig1_w};
    assign value_inc_w = value_q + 6'd1;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == EMPTY && accept_w && legal_w) begin
            state_d = LOCKED;
        end
    end

    always_comb begin
        value_valid = (state_q == LOCKED);
        load_w      = 1'b0;
        update_d    = 1'b0;
        seq_err_d   = 1'b0;
        bad_d       = 1'b0;
        if (accept_w) begin
            if (!legal_w) begin
                bad_d = 1'b1;
            end else if (state_q == EMPTY) begin
                load_w   = 1'b1;
                update_d = 1'b1;
            end else if (n_w != value_q) begin
                load_w    = 1'b1;
                update_d  = 1'b1;
                seq_err_d = (n_w != value_inc_w) && (n_w != 6'd0);
            end
        end
    end

    // seq_err and bad_pattern never coincide, so one increment covers both.
    assign value_d = load_w ? n_w : value_q;
    assign err_d   = ((seq_err_d || bad_d) && (err_q != 8'hFF)) ? err_q + 8'd1 : err_q;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            s_q       <= '0;
            cnt_q     <= '0;
            value_q   <= '0;
            update_q  <= 1'b0;
            seq_err_q <= 1'b0;
            bad_q     <= 1'b0;
            err_q     <= '0;
        end else begin
            s_q       <= sample_w;
            cnt_q     <= cnt_d;
            value_q   <= value_d;
            update_q  <= update_d;
            seq_err_q <= seq_err_d;
            bad_q     <= bad_d;
            err_q     <= err_d;
        end
    end

    assign value       = value_q;
    assign update      = update_q;
    assign seq_err     = seq_err_q;
    assign bad_pattern = bad_q;
    assign err_count   = err_q;

endmodule
